// File: rtl/slot_payout_ctrl_if.sv
// Handshake bundle between the reel/bet stage, the payout controller and the display.
interface slot_payout_ctrl_if;
    logic        spin_in;
    logic [3:0]  bet;
    logic [11:0] reels;
    logic [7:0]  credits;
    logic [7:0]  win;
    logic        busy;
    logic        win_flag;
    logic        jackpot;
    logic        reject;

    modport master (
        output spin_in, bet, reels,
        input  credits, win, busy, win_flag, jackpot, reject
    );

    modport slave (
        input  spin_in, bet, reels,
        output credits, win, busy, win_flag, jackpot, reject
    );
endinterface

// File: rtl/slot_payout_ctrl.sv
// Slot machine credit bank: debits the bet, scores the reels and pays winnings one credit per
// PAY_DIV clock cycles so the display counts up visibly.
module slot_payout_ctrl #(
    parameter int unsigned INIT_CREDITS = 50,
    parameter int unsigned JACKPOT_MULT = 10,
    parameter int unsigned PAIR_MULT    = 2,
    parameter int unsigned PAY_DIV      = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    slot_payout_ctrl_if.slave   bus
);

    localparam int unsigned     TickW    = (PAY_DIV > 1) ? $clog2(PAY_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(PAY_DIV - 1);
    localparam logic [3:0]      JackMult = 4'(JACKPOT_MULT);
    localparam logic [3:0]      PairMult = 4'(PAIR_MULT);

    typedef enum logic [1:0] {StIdle, StCapture, StEval, StPay} state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q, edge_q;
    logic [7:0]       credits_q, credits_d;
    logic [7:0]       win_q, win_d;
    logic             win_flag_q, win_flag_d;
    logic             jackpot_q, jackpot_d;
    logic             reject_q, reject_d;
    logic [3:0]       bet_q, bet_d;
    logic [11:0]      reels_q, reels_d;
    logic [7:0]       pay_left_q, pay_left_d;
    logic [TickW-1:0] tick_q, tick_d;

    logic             spin_req;
    logic             is_jackpot;
    logic [3:0]       mult;
    logic [8:0]       product;
    logic [7:0]       win_calc;

    // Rising edge of the synchronised button; held level yields a single request.
    assign spin_req = sync2_q & ~edge_q;

    // Score the captured reels; L==R alone is deliberately not a winning pattern.
    always_comb begin
        is_jackpot = 1'b0;
        mult       = 4'd0;
        if (reels_q[11:8] == reels_q[7:4] && reels_q[7:4] == reels_q[3:0]) begin
            is_jackpot = 1'b1;
            mult       = JackMult;
        end else if (reels_q[11:8] == reels_q[7:4] || reels_q[7:4] == reels_q[3:0]) begin
            mult = PairMult;
        end
        product  = 9'(bet_q) * 9'(mult);
        win_calc = product[8] ? 8'hFF : product[7:0];
    end

    // Next-state logic for the spin / evaluate / pay sequence.
    always_comb begin
        state_d    = state_q;
        credits_d  = credits_q;
        win_d      = win_q;
        win_flag_d = win_flag_q;
        jackpot_d  = jackpot_q;
        reject_d   = 1'b0;
        bet_d      = bet_q;
        reels_d    = reels_q;
        pay_left_d = pay_left_q;
        tick_d     = tick_q;
        unique case (state_q)
            StIdle: begin
                if (spin_req) begin
                    if (bus.bet == 4'd0 || {4'd0, bus.bet} > credits_q) begin
                        reject_d = 1'b1;
                    end else begin
                        credits_d  = credits_q - {4'd0, bus.bet};
                        bet_d      = bus.bet;
                        win_d      = 8'd0;
                        win_flag_d = 1'b0;
                        jackpot_d  = 1'b0;
                        state_d    = StCapture;
                    end
                end
            end
            StCapture: begin
                reels_d = bus.reels;
                state_d = StEval;
            end
            StEval: begin
                win_d      = win_calc;
                win_flag_d = (win_calc != 8'd0);
                jackpot_d  = is_jackpot;
                if (win_calc == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    pay_left_d = win_calc;
                    tick_d     = '0;
                    state_d    = StPay;
                end
            end
            StPay: begin
                if (tick_q == TickLast) begin
                    tick_d = '0;
                    if (credits_q == 8'hFF) begin
                        // Bank full: forfeit whatever is still owed.
                        pay_left_d = 8'd0;
                        state_d    = StIdle;
                    end else begin
                        credits_d  = credits_q + 8'd1;
                        pay_left_d = pay_left_q - 8'd1;
                        if (pay_left_q == 8'd1) begin
                            state_d = StIdle;
                        end
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and synchroniser registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            edge_q     <= 1'b0;
            credits_q  <= 8'(INIT_CREDITS);
            win_q      <= 8'd0;
            win_flag_q <= 1'b0;
            jackpot_q  <= 1'b0;
            reject_q   <= 1'b0;
            bet_q      <= 4'd0;
            reels_q    <= 12'd0;
            pay_left_q <= 8'd0;
            tick_q     <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= bus.spin_in;
            sync2_q    <= sync1_q;
            edge_q     <= sync2_q;
            credits_q  <= credits_d;
            win_q      <= win_d;
            win_flag_q <= win_flag_d;
            jackpot_q  <= jackpot_d;
            reject_q   <= reject_d;
            bet_q      <= bet_d;
            reels_q    <= reels_d;
            pay_left_q <= pay_left_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.credits  = credits_q;
    assign bus.win      = win_q;
    assign bus.win_flag = win_flag_q;
    assign bus.jackpot  = jackpot_q;
    assign bus.reject   = reject_q;
    assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_slot_payout_ctrl.sv
// Bench for slot_payout_ctrl: directed scenarios plus random spins against a payout model.
module tb_slot_payout_ctrl;

    localparam int unsigned INIT = 50;
    localparam int unsigned JM   = 10;
    localparam int unsigned PM   = 2;
    localparam int unsigned PD   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Model of the bank and last-spin outputs.
    int   m_credits;
    int   m_win;
    bit   m_jack;

    slot_payout_ctrl_if bus_if ();

    slot_payout_ctrl #(
        .INIT_CREDITS (INIT),
        .JACKPOT_MULT (JM),
        .PAIR_MULT    (PM),
        .PAY_DIV      (PD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    function automatic int mult_of(input logic [11:0] r);
        int l = int'(r[11:8]);
        int m = int'(r[7:4]);
        int s = int'(r[3:0]);
        if (l == m && m == s) return JM;
        if (l == m || m == s) return PM;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.spin_in = 1'b0;
        bus_if.bet = 4'd0;
        bus_if.reels = 12'd0;
        repeat (3) tick();
        m_credits = INIT;
        m_win = 0;
        m_jack = 0;
        checks++;
        if (bus_if.credits !== 8'(INIT) || bus_if.win !== 8'd0 || bus_if.busy !== 1'b0 ||
            bus_if.win_flag !== 1'b0 || bus_if.jackpot !== 1'b0 || bus_if.reject !== 1'b0) begin
            errors++;
            $display("FAIL reset: credits=%0d win=%0d busy=%b wf=%b jp=%b rej=%b required 50/0/0/0/0/0",
                     bus_if.credits, bus_if.win, bus_if.busy, bus_if.win_flag, bus_if.jackpot,
                     bus_if.reject);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete spin from button press to idle, checked cycle by cycle against the model.
    task automatic run_spin(input logic [3:0] b, input logic [11:0] r, input bit overlap,
                            input string tag);
        int  lat, n, exp_n, c0, w, exp_c;
        bit  rej;
        rej = (b == 0) || (int'(b) > m_credits);
        @(negedge clk);
        bus_if.bet = b;
        bus_if.reels = r;
        bus_if.spin_in = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus_if.busy && !bus_if.reject && lat < 8);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL %s request latency: got %0d cycles required 3", tag, lat);
        end
        if (rej) begin
            checks++;
            if (bus_if.reject !== 1'b1 || bus_if.busy !== 1'b0 ||
                bus_if.credits !== 8'(m_credits) || bus_if.win !== 8'(m_win)) begin
                errors++;
                $display("FAIL %s reject: rej=%b busy=%b credits=%0d win=%0d required 1/0/%0d/%0d",
                         tag, bus_if.reject, bus_if.busy, bus_if.credits, bus_if.win,
                         m_credits, m_win);
            end
            tick();
            checks++;
            if (bus_if.reject !== 1'b0) begin
                errors++;
                $display("FAIL %s reject width: reject=%b after one cycle required 0", tag,
                         bus_if.reject);
            end
        end else begin
            m_credits -= int'(b);
            w = int'(b) * mult_of(r);
            if (w > 255) w = 255;
            checks++;
            if (bus_if.credits !== 8'(m_credits) || bus_if.win !== 8'd0 ||
                bus_if.win_flag !== 1'b0 || bus_if.jackpot !== 1'b0) begin
                errors++;
                $display("FAIL %s debit: credits=%0d win=%0d wf=%b jp=%b required %0d/0/0/0",
                         tag, bus_if.credits, bus_if.win, bus_if.win_flag, bus_if.jackpot,
                         m_credits);
            end
            tick();
            tick();
            m_win = w;
            m_jack = (mult_of(r) == JM) && (r[11:8] == r[3:0]);
            checks++;
            if (bus_if.win !== 8'(w) || bus_if.win_flag !== (w != 0) ||
                bus_if.jackpot !== m_jack || bus_if.busy !== (w != 0)) begin
                errors++;
                $display("FAIL %s eval: win=%0d wf=%b jp=%b busy=%b required %0d/%b/%b/%b",
                         tag, bus_if.win, bus_if.win_flag, bus_if.jackpot, bus_if.busy, w,
                         (w != 0), m_jack, (w != 0));
            end
            // Inputs moving after capture must not disturb the payout.
            bus_if.bet = 4'($urandom_range(0, 15));
            bus_if.reels = 12'($urandom);
            if (w != 0) begin
                c0 = m_credits;
                exp_n = (c0 + w <= 255) ? w * PD : (256 - c0) * PD;
                n = 0;
                while (bus_if.busy && n < exp_n + 20) begin
                    tick();
                    n++;
                    if (overlap && n == 2) bus_if.spin_in = 1'b0;
                    if (overlap && n == 6) bus_if.spin_in = 1'b1;
                    exp_c = c0 + ((n / PD < 255 - c0) ? n / PD : 255 - c0);
                    checks++;
                    if (bus_if.credits !== 8'(exp_c)) begin
                        errors++;
                        $display("FAIL %s payout step %0d: credits=%0d required %0d", tag, n,
                                 bus_if.credits, exp_c);
                    end
                end
                checks++;
                if (n != exp_n) begin
                    errors++;
                    $display("FAIL %s payout duration: got %0d cycles required %0d", tag, n,
                             exp_n);
                end
                m_credits = (c0 + w > 255) ? 255 : c0 + w;
            end
        end
        repeat (4) tick();
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.credits !== 8'(m_credits) || bus_if.win !== 8'(m_win)) begin
            errors++;
            $display("FAIL %s settle: busy=%b credits=%0d win=%0d required 0/%0d/%0d", tag,
                     bus_if.busy, bus_if.credits, bus_if.win, m_credits, m_win);
        end
        @(negedge clk);
        bus_if.spin_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_pair();
        run_spin(4'd3, 12'h55A, 1'b1, "pair_overlap");
    endtask

    task automatic test_no_win();
        run_spin(4'd4, 12'h3A3, 1'b0, "l_eq_r_only");
    endtask

    task automatic test_reject();
        run_spin(4'd0, 12'h555, 1'b0, "reject_bet0");
        test_reset();
        run_spin(4'd15, 12'h123, 1'b0, "drain1");
        run_spin(4'd15, 12'h123, 1'b0, "drain2");
        run_spin(4'd12, 12'h123, 1'b0, "drain3");
        run_spin(4'd9, 12'h777, 1'b0, "reject_bet9_credits8");
    endtask

    task automatic test_jackpot();
        test_reset();
        run_spin(4'd15, 12'h777, 1'b0, "jackpot");
        run_spin(4'd15, 12'h777, 1'b0, "jackpot_saturate");
    endtask

    task automatic test_hold();
        int  rises;
        bit  prev;
        rises = 0;
        prev = 1'b0;
        @(negedge clk);
        bus_if.bet = 4'd1;
        bus_if.reels = 12'h123;
        bus_if.spin_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus_if.busy && !prev) rises++;
            prev = bus_if.busy;
        end
        m_credits -= 1;
        m_win = 0;
        m_jack = 0;
        checks++;
        if (rises != 1 || bus_if.credits !== 8'(m_credits)) begin
            errors++;
            $display("FAIL hold_spin: spins=%0d credits=%0d required 1/%0d", rises,
                     bus_if.credits, m_credits);
        end
        @(negedge clk);
        bus_if.spin_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_abort();
        int n;
        @(negedge clk);
        bus_if.bet = 4'd3;
        bus_if.reels = 12'h55A;
        bus_if.spin_in = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus_if.busy && n < 10);
        repeat (5) tick();
        checks++;
        if (bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: busy=%b required 1", bus_if.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (bus_if.credits !== 8'(INIT) || bus_if.busy !== 1'b0 || bus_if.win !== 8'd0 ||
            bus_if.win_flag !== 1'b0 || bus_if.jackpot !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: credits=%0d busy=%b win=%0d wf=%b jp=%b required 50/0/0/0/0",
                     bus_if.credits, bus_if.busy, bus_if.win, bus_if.win_flag, bus_if.jackpot);
        end
        @(negedge clk);
        rst = 1'b0;
        bus_if.spin_in = 1'b0;
        m_credits = INIT;
        m_win = 0;
        m_jack = 0;
        repeat (4) tick();
    endtask

    task automatic test_random();
        logic [11:0] r;
        test_reset();
        for (int i = 0; i < 30; i++) begin
            r = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))};
            run_spin(4'($urandom_range(0, 15)), r, 1'b0, $sformatf("random%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_no_win();
        test_reject();
        test_jackpot();
        test_hold();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
